// File: rtl/csr_access_ctrl.sv
// Zicsr access sequencer: arbitrates pipeline/debug ports and performs
// read-modify-write onto a single-port CSR file.
module csr_access_ctrl #(
  parameter int unsigned MAX_DBG_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pl_req_valid,
  output logic        pl_req_ready,
  input  logic [11:0] pl_csr_num,
  input  logic [2:0]  pl_funct3,
  input  logic [31:0] pl_src,
  input  logic        pl_src_is_x0,
  output logic        pl_resp_valid,
  output logic [31:0] pl_resp_rdata,
  output logic        pl_resp_illegal,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic [11:0] dbg_csr_num,
  input  logic        dbg_write,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_resp_valid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_illegal,
  output logic [11:0] csr_num,
  output logic        read_csr,
  input  logic [31:0] read_value,
  output logic        write_csr,
  output logic [2:0]  write_function,
  output logic [31:0] write_value,
  input  logic        illegal_instr_exception
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DBG_STREAK);

  logic [1:0]  state;
  logic [3:0]  streak;
  logic        own_dbg;
  logic [11:0] num_q;
  logic [2:0]  f3_q;
  logic [31:0] src_q;
  logic [31:0] old_q;
  logic        x0_q;
  logic        dw_q;
  logic        fault_q;
  logic        ill_q;

  logic        idle;
  logic        streak_max;
  logic        dbg_win;
  logic        pl_win;
  logic [31:0] new_val;
  logic        wr_need;
  logic        bad_f3;
  logic        illegal;

  assign idle       = (state == S_IDLE);
  assign streak_max = (streak == STREAK_MAX);
  assign dbg_win    = dbg_req_valid &&
                      !(streak_max && pl_req_valid);
  assign pl_win     = pl_req_valid && !dbg_win;

  assign dbg_req_ready = idle && dbg_win;
  assign pl_req_ready  = idle && pl_win;

  always_comb begin
    new_val = src_q;
    wr_need = 1'b1;
    bad_f3  = 1'b0;
    if (own_dbg) begin
      wr_need = dw_q;
    end else begin
      unique case (1'b1)
        (f3_q inside {3'b001, 3'b101}): ;
        (f3_q inside {3'b010, 3'b110}): begin
          new_val = old_q | src_q;
          wr_need = !x0_q;
        end
        (f3_q inside {3'b011, 3'b111}): begin
          new_val = old_q & ~src_q;
          wr_need = !x0_q;
        end
        default: bad_f3 = 1'b1;
      endcase
    end
    // top two address bits 11 mark the read-only CSR space
    illegal = fault_q || bad_f3 ||
              (wr_need && (num_q[11:10] == 2'b11));
  end

  assign read_csr       = (state == S_READ);
  assign write_csr      = (state == S_WRITE) &&
                          wr_need && !illegal;
  assign csr_num        = (read_csr || state == S_WRITE) ?
                          num_q : 12'd0;
  assign write_value    = write_csr ? new_val : 32'd0;
  assign write_function = 3'b001;

  assign pl_resp_valid   = (state == S_RESP) && !own_dbg;
  assign pl_resp_rdata   = pl_resp_valid ? old_q : 32'd0;
  assign pl_resp_illegal = pl_resp_valid && ill_q;
  assign dbg_resp_valid  = (state == S_RESP) && own_dbg;
  assign dbg_rdata       = dbg_resp_valid ? old_q : 32'd0;
  assign dbg_illegal     = dbg_resp_valid && ill_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      streak  <= 4'd0;
      own_dbg <= 1'b0;
      num_q   <= 12'd0;
      f3_q    <= 3'd0;
      src_q   <= 32'd0;
      old_q   <= 32'd0;
      x0_q    <= 1'b0;
      dw_q    <= 1'b0;
      fault_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (dbg_req_ready || pl_req_ready) begin
            state   <= S_READ;
            own_dbg <= dbg_req_ready;
            num_q   <= dbg_req_ready ? dbg_csr_num : pl_csr_num;
            src_q   <= dbg_req_ready ? dbg_wdata : pl_src;
            f3_q    <= pl_funct3;
            x0_q    <= pl_src_is_x0;
            dw_q    <= dbg_write;
          end
        end
        S_READ: begin
          old_q   <= read_value;
          fault_q <= illegal_instr_exception;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          ill_q <= illegal;
          state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
      if (!pl_req_valid || pl_req_ready) begin
        streak <= 4'd0;
      end else if (dbg_req_ready && !streak_max) begin
        streak <= streak + 4'd1;
      end
    end
  end

endmodule
